multi_key_filter: RTL and testbench
===================================

// Module: multi_key_filter
// PURPOSE
//  - Debounces NUM_KEYS independent mechanical key inputs, each with its own synchroniser, edge detector and 4-state FSM.
//  - Emits per-key one-cycle event pulses and a debounced level, with a configurable debounce time and input polarity.
//  - Sits between board push-buttons and the mode/control logic of the frame-difference pipeline.
// PARAMETERS
//  NUM_KEYS         4       number of key channels (1..16)
//  DEBOUNCE_CYCLES  240000  cycles a new level must hold before it is accepted (>=2)
//  ACTIVE_LOW       1       1: raw key reads 0 when pressed; 0: raw key reads 1 when pressed
//  LONG_CYCLES      5000000 cycles held after press acceptance before long_flag fires (LONG_PRESS_EN only; > DEBOUNCE_CYCLES)
// PORTS
//  Clk        in   1          system clock
//  Rst        in   1          reset, asynchronous, active-high
//  key_in     in   NUM_KEYS   raw asynchronous key inputs
//  key_flag   out  NUM_KEYS   1-cycle pulse per accepted press or release
//  key_press  out  NUM_KEYS   1-cycle pulse on accepted press only (coincides with key_flag)
//  key_state  out  NUM_KEYS   debounced level, 1 = released, 0 = pressed (polarity-normalised)
//  long_flag  out  NUM_KEYS   1-cycle long-press pulse (present only with LONG_PRESS_EN)
// BEHAVIOUR
//  - Reset: key_state all 1; key_flag, key_press, long_flag all 0; FSMs IDLE; counters 0; sync/edge regs load the released raw level (no spurious edge at reset exit).
//  - Per channel: 2-FF synchroniser -> 2-stage edge register -> polarity normalise -> press_edge / release_edge.
//  - FSM (one-hot, 4 states): IDLE -> FILTER0 on press_edge, counter cleared and enabled.
//    FILTER0: counter reaches DEBOUNCE_CYCLES-1 -> DOWN, key_flag=key_press=1, key_state=0; release_edge first -> IDLE, counter cleared.
//    DOWN: release_edge -> FILTER1, counter cleared and enabled.
//    FILTER1: counter reaches DEBOUNCE_CYCLES-1 -> IDLE, key_flag=1, key_state=1; press_edge first -> DOWN, counter cleared.
//    Illegal encoding -> IDLE, outputs as reset.
//  - Latency: raw edge held stable -> key_flag asserted exactly DEBOUNCE_CYCLES+4 Clk edges later. key_flag is high for exactly 1 cycle.
//  - Counter width $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)+1); saturates and never wraps. Counter idles at 0 in IDLE (and in DOWN without LONG_PRESS_EN).
//  - Glitch shorter than DEBOUNCE_CYCLES in either FILTER state: no flag, state unchanged, counter restarts from 0 on the next qualifying edge.
//  - Channels are fully independent; simultaneous events on several channels produce simultaneous pulses on the corresponding bits.
//  - Rst asserted mid-filter or mid-press: immediate return to reset values, no flag emitted. After release, a key held at reset exit is not reported until released and pressed again.
// CONFIGURATION
//  - LONG_PRESS_EN defined: long_flag port exists. In DOWN the counter keeps running from press acceptance. When it reaches LONG_CYCLES-1, long_flag pulses once; the counter then saturates, so there is one pulse per press. Entering FILTER1 clears the counter. A bounce back to DOWN restarts the long count from 0.
//  - LONG_PRESS_EN undefined: no long_flag port and no long-press logic; the counter is held at 0 in DOWN.
// STRUCTURE
//  - Package key_filter_pkg: state one-hot localparams (IDLE, FILTER0, DOWN, FILTER1) and a clog2-based counter-width function.
//  - Sub-module key_filter_chan: one channel (sync, edge, FSM, counter), instantiated NUM_KEYS times by a generate loop in multi_key_filter.
// TESTING  (NUM_KEYS=4, DEBOUNCE_CYCLES=16, LONG_CYCLES=64, ACTIVE_LOW=1)
//  - Reset release with key_in=4'hF -> no pulses for 100 cycles; key_state=4'hF.
//  - key_in[0] 1->0, held -> key_flag[0] and key_press[0] high exactly 20 cycles later for 1 cycle; key_state[0]=0. Release -> key_flag[0] pulse 20 cycles later, key_press stays 0, key_state[0]=1.
//  - key_in[1] 10-cycle low glitch, repeated 5 times -> no key_flag[1]; key_state[1] stays 1.
//  - key_in[2] and key_in[3] pressed on the same cycle -> key_flag=4'b1100 on one cycle.
//  - Rst pulsed 8 cycles into FILTER0 of key 0 -> no flag; outputs at reset values; key still low at exit -> no press reported.
//  - LONG_PRESS_EN: hold key 0 for 200 cycles -> exactly one long_flag[0], 64 cycles after key_press[0]. Without the macro -> press and release pulses only.

Source files
------------

// File: rtl/key_filter_pkg.sv
// Shared types and helpers for the multi-key debounce filter.
package key_filter_pkg;

    // One-hot channel FSM encoding; any other pattern is treated as illegal.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_FILTER0 = 4'b0010,
        ST_DOWN    = 4'b0100,
        ST_FILTER1 = 4'b1000
    } key_fsm_e;

    // Cycles after reset before synchronised edges are trusted
    // (covers the 2 sync stages plus the 2 edge stages).
    localparam int unsigned SYNC_WARMUP = 4;

    // Counter width large enough to hold the larger of the two terminal counts.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_filter_chan.sv
// One debounce channel: 2-FF synchroniser, 2-stage edge register,
// polarity normalisation, 4-state debounce FSM and saturating counter.
// Optional long-press detection is enabled by defining LONG_PRESS_EN.
module key_filter_chan
    import key_filter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 240000,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned LONG_CYCLES     = 5000000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_press,
    output logic key_state
`ifdef LONG_PRESS_EN
    ,
    output logic long_flag
`endif
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          REL_RAW   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
`ifdef LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`endif

    logic          sync1, sync2, edge0, edge1;
    logic [2:0]    warm;
    logic          armed;
    logic          lvl_new, lvl_old;
    logic          press_edge, release_edge;
    key_fsm_e      state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          flag_nxt, press_nxt, level_nxt;
`ifdef LONG_PRESS_EN
    logic          long_nxt;
`endif

    // Synchroniser and edge registers, preloaded with the released level.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync1 <= REL_RAW;
            sync2 <= REL_RAW;
            edge0 <= REL_RAW;
            edge1 <= REL_RAW;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            edge0 <= sync2;
            edge1 <= edge0;
        end
    end

    // Warm-up counter: the preloaded pipeline can show a false press edge while
    // a key held through reset propagates in; edges are ignored until it is flushed.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            warm <= '0;
        end else if (warm != 3'(SYNC_WARMUP)) begin
            warm <= warm + 3'd1;
        end
    end

    // Polarity-normalised levels (1 = released) and qualified edges.
    always_comb begin
        armed        = (warm == 3'(SYNC_WARMUP));
        lvl_new      = (ACTIVE_LOW != 0) ? edge0 : ~edge0;
        lvl_old      = (ACTIVE_LOW != 0) ? edge1 : ~edge1;
        press_edge   = armed & lvl_old & ~lvl_new;
        release_edge = armed & ~lvl_old & lvl_new;
        cnt_inc      = (cnt == '1) ? cnt : cnt + CW'(1);
    end

    // FSM state, counter and registered event outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            key_flag  <= 1'b0;
            key_press <= 1'b0;
            key_state <= 1'b1;
`ifdef LONG_PRESS_EN
            long_flag <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            key_flag  <= flag_nxt;
            key_press <= press_nxt;
            key_state <= level_nxt;
`ifdef LONG_PRESS_EN
            long_flag <= long_nxt;
`endif
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flag_nxt  = 1'b0;
        press_nxt = 1'b0;
        level_nxt = key_state;
`ifdef LONG_PRESS_EN
        long_nxt  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                cnt_nxt   = '0;
                level_nxt = 1'b1;
                if (press_edge) begin
                    state_nxt = ST_FILTER0;
                end
            end
            ST_FILTER0: begin
                if (release_edge) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = ST_DOWN;
                    cnt_nxt   = '0;
                    flag_nxt  = 1'b1;
                    press_nxt = 1'b1;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_DOWN: begin
                level_nxt = 1'b0;
                if (release_edge) begin
                    state_nxt = ST_FILTER1;
                    cnt_nxt   = '0;
                end else begin
`ifdef LONG_PRESS_EN
                    // Saturation past LONG_LAST guarantees a single pulse per press.
                    cnt_nxt  = cnt_inc;
                    long_nxt = (cnt == LONG_LAST);
`else
                    cnt_nxt  = '0;
`endif
                end
            end
            ST_FILTER1: begin
                if (press_edge) begin
                    state_nxt = ST_DOWN;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    flag_nxt  = 1'b1;
                    level_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multi_key_filter.sv
// Debounces NUM_KEYS independent key inputs; one key_filter_chan per key.
// Defining LONG_PRESS_EN adds the long_flag output and long-press detection.
module multi_key_filter
    import key_filter_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 240000,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned LONG_CYCLES     = 5000000
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_flag,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_state
`ifdef LONG_PRESS_EN
    ,
    output logic [NUM_KEYS-1:0] long_flag
`endif
);

    // One fully independent channel per key.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
        key_filter_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_chan (
            .Clk       (Clk),
            .Rst       (Rst),
            .key_in    (key_in[k]),
            .key_flag  (key_flag[k]),
            .key_press (key_press[k]),
            .key_state (key_state[k])
`ifdef LONG_PRESS_EN
            ,
            .long_flag (long_flag[k])
`endif
        );
    end

endmodule

// File: tb/tb_multi_key_filter.sv
// Directed self-checking bench for multi_key_filter (optionally with LONG_PRESS_EN).
module tb_multi_key_filter;

    logic       Clk;
    logic       Rst;
    logic [3:0] key_in;
    logic [3:0] key_flag;
    logic [3:0] key_press;
    logic [3:0] key_state;
`ifdef LONG_PRESS_EN
    logic [3:0] long_flag;
`endif

    int total;
    int bad;

    multi_key_filter #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (16),
        .ACTIVE_LOW      (1),
        .LONG_CYCLES     (64)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .key_in    (key_in),
        .key_flag  (key_flag),
        .key_press (key_press),
        .key_state (key_state)
`ifdef LONG_PRESS_EN
        ,
        .long_flag (long_flag)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic test_reset();
        Rst    = 1'b1;
        key_in = 4'hF;
        repeat (3) @(negedge Clk);
        total++;
        if ({key_flag, key_press, key_state} !== {4'h0, 4'h0, 4'hF}) begin
            bad++;
            $display("FAIL reset_hold got flag=%b press=%b state=%b exp 0000 0000 1111",
                     key_flag, key_press, key_state);
        end
        Rst = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge Clk);
            total++;
            if ({key_flag, key_press, key_state} !== {4'h0, 4'h0, 4'hF}) begin
                bad++;
                $display("FAIL reset_exit cyc=%0d got flag=%b press=%b state=%b exp 0000 0000 1111",
                         i, key_flag, key_press, key_state);
            end
`ifdef LONG_PRESS_EN
            total++;
            if (long_flag !== 4'h0) begin
                bad++;
                $display("FAIL reset_long cyc=%0d got long=%b exp 0000", i, long_flag);
            end
`endif
        end
    endtask

    task automatic test_press_release();
        logic [3:0] ef, ep, es;
        key_in[0] = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge Clk);
            ef = (i == 20) ? 4'b0001 : 4'b0000;
            ep = ef;
            es = (i >= 20) ? 4'b1110 : 4'b1111;
            total++;
            if ({key_flag, key_press, key_state} !== {ef, ep, es}) begin
                bad++;
                $display("FAIL press0 cyc=%0d got flag=%b press=%b state=%b exp %b %b %b",
                         i, key_flag, key_press, key_state, ef, ep, es);
            end
        end
        key_in[0] = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge Clk);
            ef = (i == 20) ? 4'b0001 : 4'b0000;
            es = (i >= 20) ? 4'b1111 : 4'b1110;
            total++;
            if ({key_flag, key_press, key_state} !== {ef, 4'b0000, es}) begin
                bad++;
                $display("FAIL release0 cyc=%0d got flag=%b press=%b state=%b exp %b 0000 %b",
                         i, key_flag, key_press, key_state, ef, es);
            end
        end
    endtask

    task automatic test_glitch();
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 20; i++) begin
                key_in[1] = (i < 10) ? 1'b0 : 1'b1;
                @(negedge Clk);
                total++;
                if ({key_flag, key_press, key_state} !== {4'h0, 4'h0, 4'hF}) begin
                    bad++;
                    $display("FAIL glitch1 rep=%0d cyc=%0d got flag=%b press=%b state=%b exp 0000 0000 1111",
                             g, i, key_flag, key_press, key_state);
                end
            end
        end
        repeat (20) @(negedge Clk);
        total++;
        if ({key_flag, key_state} !== {4'h0, 4'hF}) begin
            bad++;
            $display("FAIL glitch1_after got flag=%b state=%b exp 0000 1111", key_flag, key_state);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] ef, es;
        key_in[3:2] = 2'b00;
        for (int i = 1; i <= 30; i++) begin
            @(negedge Clk);
            ef = (i == 20) ? 4'b1100 : 4'b0000;
            es = (i >= 20) ? 4'b0011 : 4'b1111;
            total++;
            if ({key_flag, key_press, key_state} !== {ef, ef, es}) begin
                bad++;
                $display("FAIL simul_press cyc=%0d got flag=%b press=%b state=%b exp %b %b %b",
                         i, key_flag, key_press, key_state, ef, ef, es);
            end
        end
        key_in[3:2] = 2'b11;
        for (int i = 1; i <= 30; i++) begin
            @(negedge Clk);
            ef = (i == 20) ? 4'b1100 : 4'b0000;
            es = (i >= 20) ? 4'b1111 : 4'b0011;
            total++;
            if ({key_flag, key_press, key_state} !== {ef, 4'b0000, es}) begin
                bad++;
                $display("FAIL simul_release cyc=%0d got flag=%b press=%b state=%b exp %b 0000 %b",
                         i, key_flag, key_press, key_state, ef, es);
            end
        end
    endtask

    task automatic test_reset_mid_filter();
        logic [3:0] ef, es;
        key_in[0] = 1'b0;
        repeat (12) @(negedge Clk);
        Rst = 1'b1;
        #1;
        total++;
        if ({key_flag, key_press, key_state} !== {4'h0, 4'h0, 4'hF}) begin
            bad++;
            $display("FAIL rst_mid_async got flag=%b press=%b state=%b exp 0000 0000 1111",
                     key_flag, key_press, key_state);
        end
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge Clk);
            total++;
            if ({key_flag, key_press, key_state} !== {4'h0, 4'h0, 4'hF}) begin
                bad++;
                $display("FAIL rst_mid_held cyc=%0d got flag=%b press=%b state=%b exp 0000 0000 1111",
                         i, key_flag, key_press, key_state);
            end
        end
        key_in[0] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            total++;
            if ({key_flag, key_press, key_state} !== {4'h0, 4'h0, 4'hF}) begin
                bad++;
                $display("FAIL rst_mid_release cyc=%0d got flag=%b press=%b state=%b exp 0000 0000 1111",
                         i, key_flag, key_press, key_state);
            end
        end
        key_in[0] = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge Clk);
            ef = (i == 20) ? 4'b0001 : 4'b0000;
            es = (i >= 20) ? 4'b1110 : 4'b1111;
            total++;
            if ({key_flag, key_press, key_state} !== {ef, ef, es}) begin
                bad++;
                $display("FAIL rst_mid_repress cyc=%0d got flag=%b press=%b state=%b exp %b %b %b",
                         i, key_flag, key_press, key_state, ef, ef, es);
            end
        end
        key_in[0] = 1'b1;
        repeat (30) @(negedge Clk);
        total++;
        if (key_state !== 4'hF) begin
            bad++;
            $display("FAIL rst_mid_final got state=%b exp 1111", key_state);
        end
    endtask

    task automatic test_long_press();
        logic [3:0] ef, es, el;
        key_in[0] = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge Clk);
            ef = (i == 20) ? 4'b0001 : 4'b0000;
            es = (i >= 20) ? 4'b1110 : 4'b1111;
            total++;
            if ({key_flag, key_press, key_state} !== {ef, ef, es}) begin
                bad++;
                $display("FAIL long_hold cyc=%0d got flag=%b press=%b state=%b exp %b %b %b",
                         i, key_flag, key_press, key_state, ef, ef, es);
            end
`ifdef LONG_PRESS_EN
            el = (i == 84) ? 4'b0001 : 4'b0000;
            total++;
            if (long_flag !== el) begin
                bad++;
                $display("FAIL long_flag cyc=%0d got long=%b exp %b", i, long_flag, el);
            end
`else
            el = 4'b0000;
`endif
        end
        key_in[0] = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge Clk);
            ef = (i == 20) ? 4'b0001 : 4'b0000;
            es = (i >= 20) ? 4'b1111 : 4'b1110;
            total++;
            if ({key_flag, key_press, key_state} !== {ef, 4'b0000, es}) begin
                bad++;
                $display("FAIL long_release cyc=%0d got flag=%b press=%b state=%b exp %b 0000 %b",
                         i, key_flag, key_press, key_state, ef, es);
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        Rst    = 1'b1;
        key_in = 4'hF;
        test_reset();
        test_press_release();
        test_glitch();
        test_simultaneous();
        test_reset_mid_filter();
        test_long_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
